// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the debounce scan controller.
package debounce_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    function automatic int chan_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    // One extra pointer bit separates full from empty when the address bits match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/debounce_evt_fifo.sv
// Event FIFO with a registered head; a push into an empty queue is visible at the same edge.
module debounce_evt_fifo
    import debounce_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic             drop_o
);

    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int ADDR_W = PTR_W - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q;
    logic             empty, full, do_pop, do_push;

    assign empty   = (rd_q == wr_q);
    assign full    = (rd_q[ADDR_W] != wr_q[ADDR_W]) &&
                     (rd_q[ADDR_W-1:0] == wr_q[ADDR_W-1:0]);
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && !do_push;

    assign rd_d = rd_q + PTR_W'(do_pop);
    assign wr_d = wr_q + PTR_W'(do_push);

    // Head after this cycle: either the entry being written now or one already stored.
    always_comb begin
        head_d = '0;
        if (rd_d != wr_d) begin
            if (do_push && (rd_d == wr_q)) begin
                head_d = push_data_i;
            end else begin
                head_d = mem_q[rd_d[ADDR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push) begin
            mem_q[wr_q[ADDR_W-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            head_q  <= head_d;
            valid_q <= (rd_d != wr_d);
        end
    end

    assign head_o  = head_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Multi-channel debouncer: shared sample prescaler, round-robin scan FSM, event FIFO.
//   state | meaning
//   IDLE  | waiting for the next sample tick
//   SCAN  | evaluating channel idx this cycle, one channel per cycle
module debounce_scan_ctrl
    import debounce_pkg::*;
#(
    parameter int CH         = 8,
    parameter int TICK_DIV   = 1000,
    parameter int N          = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic [CH-1:0]         async_in_i,
    input  logic                  enable_i,
    output logic [CH-1:0]         level_out_o,
    output logic                  evt_valid_o,
    input  logic                  evt_ready_i,
    output logic [$clog2(CH)-1:0] evt_chan_o,
    output logic                  evt_rise_o,
    output logic                  overflow_o,
    input  logic                  clear_overflow_i
);

    localparam int CHAN_W  = chan_w(CH);
    localparam int CNT_W   = cnt_w(N);
    localparam int PRESC_W = $clog2(TICK_DIV);

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic              rise;
    } evt_t;

    if (TICK_DIV < CH + 2) begin : g_bad_tick_div
        $error("debounce_scan_ctrl: TICK_DIV must be >= CH+2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("debounce_scan_ctrl: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    logic [CH-1:0]      sync1_q, sync2_q;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;
    scan_state_e        state_q, state_d;
    logic [CHAN_W-1:0]  idx_q, idx_d;
    logic               scan_active;
    logic [CNT_W-1:0]   cnt_q [CH];
    logic [CNT_W-1:0]   cnt_d [CH];
    logic [CH-1:0]      level_q, level_d;
    logic               push;
    evt_t               push_evt;
    evt_t               head_evt;
    logic               drop;
    logic               overflow_q, overflow_d;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= async_in_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        if (!enable_i || (presc_q == PRESC_W'(TICK_DIV - 1))) begin
            presc_d = '0;
        end
    end

    assign tick = enable_i && (presc_q == PRESC_W'(TICK_DIV - 1));

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // FSM state register
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state; a started scan ignores enable and always runs to the last channel
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                idx_d = idx_q + CHAN_W'(1);
                if (idx_q == CHAN_W'(CH - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        scan_active = (state_q == SCAN);
    end

    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        push     = 1'b0;
        push_evt = '0;
        if (scan_active) begin
            if (sync2_q[idx_q] == level_q[idx_q]) begin
                cnt_d[idx_q] = '0;
            end else if (cnt_q[idx_q] == CNT_W'(N - 1)) begin
                level_d[idx_q] = sync2_q[idx_q];
                cnt_d[idx_q]   = '0;
                push           = 1'b1;
                push_evt.chan  = idx_q;
                push_evt.rise  = sync2_q[idx_q];
            end else begin
                cnt_d[idx_q] = cnt_q[idx_q] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            level_q <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    debounce_evt_fifo #(
        .WIDTH (CHAN_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clock_i     (clock_i),
        .reset_n_i   (reset_n_i),
        .push_i      (push),
        .push_data_i (push_evt),
        .pop_i       (evt_ready_i),
        .head_o      (head_evt),
        .valid_o     (evt_valid_o),
        .drop_o      (drop)
    );

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign level_out_o = level_q;
    assign evt_chan_o  = head_evt.chan;
    assign evt_rise_o  = head_evt.rise;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed bench for debounce_scan_ctrl with CH=4, TICK_DIV=16, N=3, FIFO_DEPTH=4.
module tb_debounce_scan_ctrl;

    localparam int CH         = 4;
    localparam int TICK_DIV   = 16;
    localparam int N          = 3;
    localparam int FIFO_DEPTH = 4;

    typedef logic [2:0] ev_arr_t [5];

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [CH-1:0] async_in = '0;
    logic          enable = 1'b1;
    logic [CH-1:0] level_out;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [1:0]    evt_chan;
    logic          evt_rise;
    logic          overflow;
    logic          clear_overflow = 1'b0;

    int         n_checks = 0;
    int         n_errors = 0;
    int         ecnt = 0;
    logic [2:0] evq [$];

    debounce_scan_ctrl #(
        .CH         (CH),
        .TICK_DIV   (TICK_DIV),
        .N          (N),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock_i          (clk),
        .reset_n_i        (reset_n),
        .async_in_i       (async_in),
        .enable_i         (enable),
        .level_out_o      (level_out),
        .evt_valid_o      (evt_valid),
        .evt_ready_i      (evt_ready),
        .evt_chan_o       (evt_chan),
        .evt_rise_o       (evt_rise),
        .overflow_o       (overflow),
        .clear_overflow_i (clear_overflow)
    );

    always #5 clk = ~clk;

    // Every accepted event, recorded as {chan, rise}.
    always @(negedge clk) begin
        if (reset_n && evt_valid && evt_ready) begin
            evq.push_back({evt_chan, evt_rise});
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to edge number target after reset release, then sample 1ns later.
    task automatic step_to(input int target);
        while (ecnt < target) begin
            @(posedge clk);
            ecnt++;
        end
        #1;
    endtask

    task automatic do_reset(input logic [CH-1:0] a, input logic rdy);
        async_in  = a;
        evt_ready = rdy;
        enable    = 1'b1;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        ecnt    = 0;
        evq.delete();
    endtask

    task automatic check_q(input string tag, input int len, input ev_arr_t exp);
        chk({tag, "_len"}, evq.size(), len);
        for (int i = 0; i < len; i++) begin
            if (i < evq.size()) begin
                chk($sformatf("%s_ev%0d", tag, i), evq[i], exp[i]);
            end
        end
    endtask

    initial begin
        // Reset with all inputs high, then a full-FIFO push coinciding with a pop
        do_reset(4'hF, 1'b0);
        chk("rst_level", level_out, 4'h0);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_head", {evt_chan, evt_rise}, 3'b000);
        step_to(48);
        chk("rst_level_e48", level_out, 4'h0);
        chk("rst_valid_e48", evt_valid, 1'b0);
        step_to(49);
        chk("rst_level_e49", level_out, 4'h1);
        chk("rst_valid_e49", evt_valid, 1'b1);
        chk("rst_head_e49", {evt_chan, evt_rise}, 3'b001);
        step_to(52);
        chk("rst_level_e52", level_out, 4'hF);
        step_to(55);
        async_in = 4'hE;
        step_to(96);
        chk("full_level_e96", level_out, 4'hF);
        evt_ready = 1'b1;
        step_to(97);
        evt_ready = 1'b0;
        chk("fullpop_ovf", overflow, 1'b0);
        chk("fullpop_level", level_out, 4'hE);
        chk("fullpop_head", {evt_chan, evt_rise}, 3'b011);
        step_to(98);
        evt_ready = 1'b1;
        step_to(106);
        chk("fullpop_drained", evt_valid, 1'b0);
        chk("fullpop_ovf_end", overflow, 1'b0);
        check_q("fullpop_q", 5, '{3'b001, 3'b011, 3'b101, 3'b111, 3'b000});

        // Clean press and release on channel 2 with the consumer always ready
        do_reset(4'h0, 1'b1);
        step_to(3);
        async_in = 4'h4;
        step_to(50);
        chk("press_level_e50", level_out, 4'h0);
        step_to(51);
        chk("press_level_e51", level_out, 4'h4);
        chk("press_head", {evt_valid, evt_chan, evt_rise}, 4'b1101);
        step_to(53);
        chk("press_popped", evt_valid, 1'b0);
        async_in = 4'h0;
        step_to(98);
        chk("release_level_e98", level_out, 4'h4);
        step_to(99);
        chk("release_level_e99", level_out, 4'h0);
        step_to(104);
        check_q("press_q", 2, '{3'b101, 3'b100, 3'b000, 3'b000, 3'b000});

        // Channel 1 alternates on every tick and must never settle
        do_reset(4'h0, 1'b1);
        step_to(3);
        for (int k = 0; k < 12; k++) begin
            async_in[1] = ~async_in[1];
            step_to(ecnt + 16);
        end
        step_to(220);
        chk("bounce_level", level_out, 4'h0);
        chk("bounce_q_len", evq.size(), 0);

        // Overflow: five transitions into a four-entry FIFO
        do_reset(4'h0, 1'b0);
        step_to(5);
        async_in = 4'hF;
        step_to(55);
        chk("ovf_level_e55", level_out, 4'hF);
        async_in = 4'hE;
        step_to(96);
        chk("ovf_pre", overflow, 1'b0);
        step_to(97);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_level", level_out, 4'hE);
        chk("ovf_head", {evt_valid, evt_chan, evt_rise}, 4'b1001);
        step_to(98);
        clear_overflow = 1'b1;
        step_to(99);
        clear_overflow = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);
        evt_ready = 1'b1;
        step_to(108);
        chk("ovf_drained", evt_valid, 1'b0);
        check_q("ovf_q", 4, '{3'b001, 3'b011, 3'b101, 3'b111, 3'b000});

        // Channels 0 and 3 flip together and report in ascending order
        do_reset(4'h0, 1'b1);
        step_to(3);
        async_in = 4'h9;
        step_to(49);
        chk("simul_level_e49", level_out, 4'h1);
        step_to(52);
        chk("simul_level_e52", level_out, 4'h9);
        step_to(58);
        check_q("simul_q", 2, '{3'b001, 3'b111, 3'b000, 3'b000, 3'b000});

        // Enable dropped mid-scan: scan finishes, counters kept, no further ticks
        do_reset(4'h0, 1'b0);
        step_to(3);
        async_in = 4'h4;
        step_to(17);
        enable = 1'b0;
        step_to(117);
        chk("en_off_level", level_out, 4'h0);
        chk("en_off_valid", evt_valid, 1'b0);
        enable = 1'b1;
        step_to(151);
        chk("en_on_level_e151", level_out, 4'h0);
        step_to(152);
        chk("en_on_level_e152", level_out, 4'h4);
        chk("en_on_head", {evt_valid, evt_chan, evt_rise}, 4'b1101);

        // Reset asserted while a scan is in progress
        step_to(166);
        reset_n = 1'b0;
        step_to(167);
        chk("midrst_level", level_out, 4'h0);
        chk("midrst_head", {evt_valid, evt_chan, evt_rise}, 4'b0000);
        chk("midrst_ovf", overflow, 1'b0);
        reset_n = 1'b1;
        ecnt = 0;
        evq.delete();
        step_to(50);
        chk("midrst_relevel_e50", level_out, 4'h0);
        step_to(51);
        chk("midrst_relevel_e51", level_out, 4'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
